// File: rtl/obi_mem_arbiter_pkg.sv
// Shared types and constants for the OBI instruction/data memory arbiter.
// Requester IDs double as the payload stored in the in-order response FIFO.
package obi_arb_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  // Pointer width that stays at least one bit for a single-entry FIFO.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/obi_mem_arbiter_id_fifo.sv
// Small synchronous FIFO holding requester IDs of granted, unanswered transactions.
// Circular pointers wrap explicitly so any depth (not only powers of two) works.
module obi_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin 2:1 arbiter sharing one OBI memory port between instruction fetch
// and data accesses; responses are steered back in issue order via an ID FIFO.
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_req_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic [DATA_W-1:0]   instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i,
  output logic                protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  req_id_e          rr_q, rr_d;
  req_id_e          lock_id_q, lock_id_d;
  req_id_e          owner, head_id;
  logic             lock_q, lock_d;
  logic             protocol_err_q, protocol_err_d;
  logic             owner_req, mem_req, handshake, pop, spurious;
  logic             fifo_full, fifo_empty;
  logic [0:0]       push_id, head_raw;
  logic [CNT_W-1:0] fifo_count;

  always_comb begin
    if (lock_q)                          owner = lock_id_q;
    else if (instr_req_i && data_req_i)  owner = rr_q;
    else if (data_req_i)                 owner = REQ_DATA;
    else                                 owner = REQ_INSTR;
  end

  // Gate on registered fullness only, so rvalid never feeds mem_req_o.
  assign owner_req = (owner == REQ_DATA) ? data_req_i : instr_req_i;
  assign mem_req   = rst && owner_req && !fifo_full;
  assign handshake = mem_req && mem_gnt_i;
  assign pop       = rst && mem_rvalid_i && (fifo_count != '0);
  assign spurious  = mem_rvalid_i && fifo_empty;
  assign push_id   = owner;
  assign head_id   = req_id_e'(head_raw);

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (handshake),
    .pop_i   (pop),
    .data_i  (push_id),
    .data_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    mem_req_o      = mem_req;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = handshake && (owner == REQ_INSTR);
    data_gnt_o     = handshake && (owner == REQ_DATA);
    instr_rvalid_o = pop && (head_id == REQ_INSTR);
    data_rvalid_o  = pop && (head_id == REQ_DATA);
    instr_rdata_o  = rst ? mem_rdata_i : '0;
    data_rdata_o   = rst ? mem_rdata_i : '0;
    instr_err_o    = mem_err_i && instr_rvalid_o;
    data_err_o     = mem_err_i && data_rvalid_o;
    protocol_err_o = protocol_err_q;
    if (rst) begin
      if (owner == REQ_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  always_comb begin
    rr_d           = rr_q;
    lock_d         = lock_q;
    lock_id_d      = lock_id_q;
    protocol_err_d = protocol_err_q || spurious;
    if (handshake) begin
      lock_d = 1'b0;
      rr_d   = (owner == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    end else if (mem_req) begin
      lock_d    = 1'b1;
      lock_id_d = owner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q           <= REQ_INSTR;
      lock_q         <= 1'b0;
      lock_id_q      <= REQ_INSTR;
      protocol_err_q <= 1'b0;
    end else begin
      rr_q           <= rr_d;
      lock_q         <= lock_d;
      lock_id_q      <= lock_id_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed testbench for obi_mem_arbiter: one task per scenario, inline checks.
// Flag vector order: mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_err, data_err, protocol_err.
module tb_obi_mem_arbiter;

  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h0000_2000;

  logic        clk, rst;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i, protocol_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  flags;
  int          checks = 0;
  int          errors = 0;

  assign flags = {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                  instr_err_o, data_err_o, protocol_err_o};

  obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .protocol_err_o(protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus at the falling edge, then settle before checks.
  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic gnt, input logic rv,
                       input logic err, input logic [31:0] rdata);
    @(negedge clk);
    instr_req_i  = ireq;  instr_addr_i = iaddr;
    data_req_i   = dreq;  data_we_i    = dwe;   data_be_i = dbe;
    data_addr_i  = daddr; data_wdata_i = dwdata;
    mem_gnt_i    = gnt;   mem_rvalid_i = rv;    mem_err_i = err; mem_rdata_i = rdata;
    #1;
    $display("txn t=%0t rst=%b ireq=%b dreq=%b gnt=%b rvalid=%b -> flags=%b addr=%h",
             $time, rst, ireq, dreq, gnt, rv, flags, mem_addr_o);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, IA, 1, 1, 4'h3, DA, 32'h1234_5678, 1, 1, 1, 32'hCAFE_F00D);
    checks++; if (flags !== 8'b0000_0000) begin errors++;
      $display("FAIL reset_flags got=%b exp=%b", flags, 8'b0000_0000); end
    checks++; if ({mem_addr_o, mem_wdata_o, instr_rdata_o, data_rdata_o, mem_be_o, mem_we_o} !== '0) begin errors++;
      $display("FAIL reset_buses got addr=%h wdata=%h irdata=%h drdata=%h be=%h we=%b exp all zero",
               mem_addr_o, mem_wdata_o, instr_rdata_o, data_rdata_o, mem_be_o, mem_we_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (flags !== 8'b0000_0000) begin errors++;
      $display("FAIL post_reset_flags got=%b exp=%b", flags, 8'b0000_0000); end
  endtask

  task automatic test_instr_only();
    drive(1, IA, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1100_0000) begin errors++;
      $display("FAIL instr_req_flags got=%b exp=%b", flags, 8'b1100_0000); end
    checks++; if ({mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o} !== {IA, 4'hF, 1'b0, 32'h0}) begin errors++;
      $display("FAIL instr_req_bus got addr=%h be=%h we=%b wdata=%h exp addr=%h be=f we=0 wdata=0",
               mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o, IA); end
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
    checks++; if (flags !== 8'b0001_0000) begin errors++;
      $display("FAIL instr_rsp_flags got=%b exp=%b", flags, 8'b0001_0000); end
    checks++; if (instr_rdata_o !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL instr_rsp_rdata got=%h exp=%h", instr_rdata_o, 32'hDEAD_BEEF); end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(1, IA, 1, 0, 4'hF, DA, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1100_0000 || mem_addr_o !== IA) begin errors++;
      $display("FAIL rr_c0 got flags=%b addr=%h exp flags=11000000 addr=%h", flags, mem_addr_o, IA); end
    drive(1, IA, 1, 0, 4'hF, DA, 0, 1, 1, 0, 32'hA1A1_A1A1);
    checks++; if (flags !== 8'b1011_0000 || mem_addr_o !== DA) begin errors++;
      $display("FAIL rr_c1 got flags=%b addr=%h exp flags=10110000 addr=%h", flags, mem_addr_o, DA); end
    checks++; if (instr_rdata_o !== 32'hA1A1_A1A1) begin errors++;
      $display("FAIL rr_c1_rdata got=%h exp=%h", instr_rdata_o, 32'hA1A1_A1A1); end
    drive(1, IA, 1, 0, 4'hF, DA, 0, 1, 1, 0, 32'hA2A2_A2A2);
    checks++; if (flags !== 8'b1100_1000 || data_rdata_o !== 32'hA2A2_A2A2) begin errors++;
      $display("FAIL rr_c2 got flags=%b rdata=%h exp flags=11001000 rdata=a2a2a2a2", flags, data_rdata_o); end
    drive(1, IA, 1, 0, 4'hF, DA, 0, 1, 1, 0, 32'hA3A3_A3A3);
    checks++; if (flags !== 8'b1011_0000) begin errors++;
      $display("FAIL rr_c3 got=%b exp=%b", flags, 8'b1011_0000); end
    drive(0, IA, 0, 0, 4'hF, DA, 0, 0, 1, 0, 32'hA4A4_A4A4);
    checks++; if (flags !== 8'b0000_1000 || data_rdata_o !== 32'hA4A4_A4A4) begin errors++;
      $display("FAIL rr_c4 got flags=%b rdata=%h exp flags=00001000 rdata=a4a4a4a4", flags, data_rdata_o); end
  endtask

  task automatic test_lock();
    drive(1, IA, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1100_0000) begin errors++;
      $display("FAIL lock_c0 got=%b exp=%b", flags, 8'b1100_0000); end
    for (int c = 1; c <= 3; c++) begin
      drive(1, IA, 1, 1, 4'h3, DA, 32'h1234_5678, 0, (c == 1), 0, 32'h1111_1111);
      checks++; if (flags !== ((c == 1) ? 8'b1001_0000 : 8'b1000_0000)) begin errors++;
        $display("FAIL lock_stall_c%0d got=%b exp=%b", c, flags, (c == 1) ? 8'b1001_0000 : 8'b1000_0000); end
      checks++; if ({mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o} !== {DA, 32'h1234_5678, 4'h3, 1'b1}) begin errors++;
        $display("FAIL lock_stable_c%0d got addr=%h wdata=%h be=%h we=%b exp addr=%h wdata=12345678 be=3 we=1",
                 c, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o, DA); end
    end
    drive(1, IA, 1, 1, 4'h3, DA, 32'h1234_5678, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1010_0000) begin errors++;
      $display("FAIL lock_c4_gnt got=%b exp=%b", flags, 8'b1010_0000); end
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2222_2222);
    checks++; if (flags !== 8'b0000_1000) begin errors++;
      $display("FAIL lock_c5_rsp got=%b exp=%b", flags, 8'b0000_1000); end
    // Data locks the port while rr points at INSTR; a late instr request must not steal it.
    drive(0, IA, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0, 0);
    checks++; if (flags !== 8'b1000_0000 || mem_addr_o !== 32'h3000) begin errors++;
      $display("FAIL lock_c6 got flags=%b addr=%h exp flags=10000000 addr=00003000", flags, mem_addr_o); end
    drive(1, IA, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0, 0);
    checks++; if (flags !== 8'b1000_0000 || mem_addr_o !== 32'h3000) begin errors++;
      $display("FAIL lock_hold got flags=%b addr=%h exp flags=10000000 addr=00003000", flags, mem_addr_o); end
    drive(1, IA, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1010_0000) begin errors++;
      $display("FAIL lock_c8 got=%b exp=%b", flags, 8'b1010_0000); end
    drive(1, IA, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3333_3333);
    checks++; if (flags !== 8'b1100_1000) begin errors++;
      $display("FAIL lock_c9 got=%b exp=%b", flags, 8'b1100_1000); end
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4444_4444);
    checks++; if (flags !== 8'b0001_0000) begin errors++;
      $display("FAIL lock_c10 got=%b exp=%b", flags, 8'b0001_0000); end
  endtask

  task automatic test_full();
    logic [7:0] exp_f [7] = '{8'b1100_0000, 8'b1100_0000, 8'b0000_0000, 8'b0001_0000,
                              8'b1100_0000, 8'b0001_0000, 8'b0001_0000};
    logic       ireq_v [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic       rv_v   [7] = '{0, 0, 0, 1, 0, 1, 1};
    for (int c = 0; c < 7; c++) begin
      drive(ireq_v[c], IA, 0, 0, 0, 0, 0, 1, rv_v[c], 0, 32'h5A5A_0000 + c);
      checks++; if (flags !== exp_f[c]) begin errors++;
        $display("FAIL full_c%0d got=%b exp=%b", c, flags, exp_f[c]); end
    end
  endtask

  task automatic test_error();
    drive(0, IA, 1, 0, 4'hF, 32'h4000, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1010_0000) begin errors++;
      $display("FAIL err_c0 got=%b exp=%b", flags, 8'b1010_0000); end
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 1, 32'hBAD0_BAD0);
    checks++; if (flags !== 8'b0000_1010 || data_rdata_o !== 32'hBAD0_BAD0) begin errors++;
      $display("FAIL err_rsp got flags=%b rdata=%h exp flags=00001010 rdata=bad0bad0", flags, data_rdata_o); end
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 0, 32'h5555_5555);
    checks++; if (flags !== 8'b0000_0000) begin errors++;
      $display("FAIL err_spurious got=%b exp=%b", flags, 8'b0000_0000); end
    for (int c = 0; c < 2; c++) begin
      drive(0, IA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (flags !== 8'b0000_0001) begin errors++;
        $display("FAIL err_sticky_%0d got=%b exp=%b", c, flags, 8'b0000_0001); end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, IA, 1, 0, 4'hF, DA, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1010_0001) begin errors++;
      $display("FAIL rmid_c0 got=%b exp=%b", flags, 8'b1010_0001); end
    drive(1, IA, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1100_0001) begin errors++;
      $display("FAIL rmid_c1 got=%b exp=%b", flags, 8'b1100_0001); end
    rst = 1'b0;
    drive(1, IA, 1, 1, 4'h3, DA, 32'h1234_5678, 1, 1, 1, 32'h6666_6666);
    checks++; if (flags !== 8'b0000_0000) begin errors++;
      $display("FAIL rmid_in_reset_flags got=%b exp=%b", flags, 8'b0000_0000); end
    checks++; if ({mem_addr_o, mem_wdata_o, instr_rdata_o, data_rdata_o, mem_be_o, mem_we_o} !== '0) begin errors++;
      $display("FAIL rmid_in_reset_buses got addr=%h wdata=%h irdata=%h be=%h exp all zero",
               mem_addr_o, mem_wdata_o, instr_rdata_o, mem_be_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 0, 32'h7777_7777);
    checks++; if (flags !== 8'b0000_0000) begin errors++;
      $display("FAIL rmid_stale_rsp got=%b exp=%b", flags, 8'b0000_0000); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (flags !== 8'b0000_0001) begin errors++;
      $display("FAIL rmid_perr got=%b exp=%b", flags, 8'b0000_0001); end
    drive(1, IA, 1, 0, 4'hF, DA, 0, 1, 0, 0, 0);
    checks++; if (flags !== 8'b1100_0001 || mem_addr_o !== IA) begin errors++;
      $display("FAIL rmid_rr_instr got flags=%b addr=%h exp flags=11000001 addr=%h", flags, mem_addr_o, IA); end
    drive(0, IA, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8888_8888);
    checks++; if (flags !== 8'b0001_0001 || instr_rdata_o !== 32'h8888_8888) begin errors++;
      $display("FAIL rmid_rsp got flags=%b rdata=%h exp flags=00010001 rdata=88888888", flags, instr_rdata_o); end
  endtask

  initial begin
    rst = 1'b1;
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
    data_addr_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
    mem_rdata_i = 0;
    #1;
    test_reset();
    test_instr_only();
    test_round_robin();
    test_lock();
    test_full();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
